apb_master_arbiter: RTL and testbench

- Two-requester APB master and arbiter that shares a single APB slave (the 64-word RAM slave) between two on-chip requesters, e.g. the AXI4-Lite bridge front-end and a debug/config port.
- Accepts one request at a time over a valid/ready interface and runs a full APB SETUP/ACCESS transfer.
- Returns read data and error status on a one-cycle response pulse.
- Round-robin fairness and an ACCESS-phase timeout keep one requester or a dead slave from locking the bus.

---
 rtl/apb_master_arbiter_pkg.sv | 16 +
 rtl/apb_master_arbiter_if.sv | 53 +++++
 rtl/apb_rr_arbiter.sv | 23 ++
 rtl/apb_master_arbiter.sv | 171 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared constants for the two-requester APB master/arbiter:
// FSM state encodings, default bus widths and timeout counter sizing.
package apb_arb_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TIMEOUT = 16;
  localparam int CNT_W       = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_SETUP  = 2'b01;
  localparam state_t ST_ACCESS = 2'b10;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Bundles both requester handshakes and the APB bus of the arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_master_arbiter_if #(
  parameter int DATA_W = apb_arb_pkg::DEF_DATA_W,
  parameter int ADDR_W = apb_arb_pkg::DEF_ADDR_W
);

  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              rsp1_err;

  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant. On a tie the requester that did not win
// last time is chosen; a lone requester always wins. Grant is one-hot
// and forced to zero when enable is low.
module apb_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // Pick requester 0 unless only requester 1 is asking or it is 1's turn.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req[0] && (!req[1] || last_grant)) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB slave between two requesters. A request is accepted in
// IDLE, driven through SETUP and ACCESS, and answered with a one-cycle
// registered response pulse. An ACCESS-phase timeout ends transfers to a
// slave that never raises PREADY.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_master_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp0_err_q, rsp0_err_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic              rsp1_err_q, rsp1_err_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic              rsp_err_v;
  logic [DATA_W-1:0] rsp_rdata_v;
  logic [1:0]        grant;
  logic              arb_en;

  // Reset is folded in so ready drops the moment PRESET rises.
  assign arb_en = (state_q == ST_IDLE) && !PRESET;

  apb_rr_arbiter u_arb (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.PADDR      = paddr_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_err   = rsp0_err_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_err   = rsp1_err_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;

  // APB sequencer: accept, SETUP, ACCESS with timeout, then respond.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    rsp0_valid_d = 1'b0;
    rsp0_err_d   = 1'b0;
    rsp0_rdata_d = '0;
    rsp1_valid_d = 1'b0;
    rsp1_err_d   = 1'b0;
    rsp1_rdata_d = '0;
    rsp_err_v    = 1'b0;
    rsp_rdata_v  = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (grant[0]) begin
          paddr_d      = bus.req0_addr;
          pwrite_d     = bus.req0_write;
          pwdata_d     = bus.req0_wdata;
          last_grant_d = 1'b0;
          psel_d       = 1'b1;
          state_d      = ST_SETUP;
        end else if (grant[1]) begin
          paddr_d      = bus.req1_addr;
          pwrite_d     = bus.req1_write;
          pwdata_d     = bus.req1_wdata;
          last_grant_d = 1'b1;
          psel_d       = 1'b1;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY || (cnt_q == CNT_LAST)) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
          rsp_err_v = bus.PREADY ? bus.PSLVERR : 1'b1;
          if (bus.PREADY && !pwrite_q && !bus.PSLVERR) begin
            rsp_rdata_v = bus.PRDATA;
          end
          if (!last_grant_q) begin
            rsp0_valid_d = 1'b1;
            rsp0_err_d   = rsp_err_v;
            rsp0_rdata_d = rsp_rdata_v;
          end else begin
            rsp1_valid_d = 1'b1;
            rsp1_err_d   = rsp_err_v;
            rsp1_rdata_d = rsp_rdata_v;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State, APB outputs and response registers; reset abandons any transfer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a 64-word APB RAM slave model
// that can stall PREADY or force PSLVERR.
module tb_apb_master_arbiter;

  logic PCLK;
  logic PRESET;
  logic slaveStall;
  logic slaveErr;
  logic [31:0] ram [64];
  int numAsserts;
  int numFails;
  int accessCycles;
  int expGrant;

  apb_master_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  apb_master_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Slave answers immediately unless stalled; error mode returns a fixed pattern.
  assign bus.PREADY  = !slaveStall;
  assign bus.PSLVERR = slaveErr && bus.PSEL && bus.PENABLE;
  assign bus.PRDATA  = slaveErr ? 32'h12345678 : ram[bus.PADDR[5:0]];

  // RAM write on a completed APB write.
  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && !slaveErr) begin
      ram[bus.PADDR[5:0]] <= bus.PWDATA;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numAsserts++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int who, input logic valid, input logic write,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (who == 0) begin
      bus.req0_valid = valid;
      bus.req0_write = write;
      bus.req0_addr  = addr;
      bus.req0_wdata = wdata;
    end else begin
      bus.req1_valid = valid;
      bus.req1_write = write;
      bus.req1_addr  = addr;
      bus.req1_wdata = wdata;
    end
  endtask

  task automatic nextCycle();
    @(posedge PCLK);
    #1;
  endtask

  // Directed sequence; all sampling happens 1 unit after a rising edge.
  initial begin
    numAsserts = 0;
    numFails   = 0;
    slaveStall = 1'b0;
    slaveErr   = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    PRESET = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 32'h05, 32'hDEADBEEF);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

    #12;
    checkOutput("rst_psel", bus.PSEL, 1'b0);
    checkOutput("rst_penable", bus.PENABLE, 1'b0);
    checkOutput("rst_ready0", bus.req0_ready, 1'b0);
    checkOutput("rst_rsp0", bus.rsp0_valid, 1'b0);
    checkOutput("rst_paddr", bus.PADDR, 32'h0);

    // Single write from requester 0.
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    checkOutput("wr_ready0", bus.req0_ready, 1'b1);
    checkOutput("wr_ready1", bus.req1_ready, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wr_setup_psel", bus.PSEL, 1'b1);
    checkOutput("wr_setup_penable", bus.PENABLE, 1'b0);
    checkOutput("wr_paddr", bus.PADDR, 32'h05);
    checkOutput("wr_pwrite", bus.PWRITE, 1'b1);
    checkOutput("wr_pwdata", bus.PWDATA, 32'hDEADBEEF);
    nextCycle();
    checkOutput("wr_access_psel", bus.PSEL, 1'b1);
    checkOutput("wr_access_penable", bus.PENABLE, 1'b1);
    checkOutput("wr_early_rsp0", bus.rsp0_valid, 1'b0);
    nextCycle();
    checkOutput("wr_rsp0_valid", bus.rsp0_valid, 1'b1);
    checkOutput("wr_rsp0_err", bus.rsp0_err, 1'b0);
    checkOutput("wr_rsp0_rdata", bus.rsp0_rdata, 32'h0);
    checkOutput("wr_psel_drop", bus.PSEL, 1'b0);
    checkOutput("wr_ram5", ram[5], 32'hDEADBEEF);
    nextCycle();
    checkOutput("wr_rsp0_pulse", bus.rsp0_valid, 1'b0);
    checkOutput("wr_paddr_hold", bus.PADDR, 32'h05);

    // Read back through requester 1.
    applyStimulus(1, 1'b1, 1'b0, 32'h05, 32'h0);
    #1;
    checkOutput("rd_ready1", bus.req1_ready, 1'b1);
    checkOutput("rd_ready0", bus.req0_ready, 1'b0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rd_pwrite", bus.PWRITE, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rd_rsp1_valid", bus.rsp1_valid, 1'b1);
    checkOutput("rd_rsp1_rdata", bus.rsp1_rdata, 32'hDEADBEEF);
    checkOutput("rd_rsp1_err", bus.rsp1_err, 1'b0);
    checkOutput("rd_rsp0_quiet", bus.rsp0_valid, 1'b0);

    // Round robin with both requesters continuously valid after reset.
    PRESET = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    checkOutput("rr_rst_ready1", bus.req1_ready, 1'b0);
    nextCycle();
    PRESET = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      expGrant = i % 2;
      checkOutput("rr_ready0", bus.req0_ready, expGrant == 0);
      checkOutput("rr_ready1", bus.req1_ready, expGrant == 1);
      nextCycle();
      checkOutput("rr_paddr", bus.PADDR, (expGrant == 0) ? 32'h10 : 32'h20);
      nextCycle();
      nextCycle();
      checkOutput("rr_rsp0", bus.rsp0_valid, expGrant == 0);
      checkOutput("rr_rsp1", bus.rsp1_valid, expGrant == 1);
    end
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    // Dead slave: ACCESS must end after exactly 16 cycles.
    slaveStall = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 32'h07, 32'hCAFEF00D);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    accessCycles = 0;
    while (bus.PENABLE && accessCycles < 40) begin
      accessCycles++;
      nextCycle();
    end
    checkOutput("to_access_len", accessCycles, 16);
    checkOutput("to_rsp0_valid", bus.rsp0_valid, 1'b1);
    checkOutput("to_rsp0_err", bus.rsp0_err, 1'b1);
    checkOutput("to_rsp0_rdata", bus.rsp0_rdata, 32'h0);
    checkOutput("to_psel", bus.PSEL, 1'b0);
    checkOutput("to_ram7", ram[7], 32'h0);
    slaveStall = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 32'h05, 32'h0);
    #1;
    checkOutput("to_next_ready1", bus.req1_ready, 1'b1);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("to_next_rdata", bus.rsp1_rdata, 32'hDEADBEEF);

    // Slave error on a read suppresses the read data.
    slaveErr = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h05, 32'h0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("err_rsp0_valid", bus.rsp0_valid, 1'b1);
    checkOutput("err_rsp0_err", bus.rsp0_err, 1'b1);
    checkOutput("err_rsp0_rdata", bus.rsp0_rdata, 32'h0);
    slaveErr = 1'b0;
    nextCycle();

    // Reset in the middle of ACCESS drops the transfer silently.
    slaveStall = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 32'h05, 32'h0);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("mr_in_access", bus.PENABLE, 1'b1);
    PRESET = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    checkOutput("mr_psel", bus.PSEL, 1'b0);
    checkOutput("mr_penable", bus.PENABLE, 1'b0);
    checkOutput("mr_ready0", bus.req0_ready, 1'b0);
    checkOutput("mr_ready1", bus.req1_ready, 1'b0);
    nextCycle();
    checkOutput("mr_no_rsp1", bus.rsp1_valid, 1'b0);
    slaveStall = 1'b0;
    PRESET = 1'b0;
    #1;
    checkOutput("mr_tie_ready0", bus.req0_ready, 1'b1);
    checkOutput("mr_tie_ready1", bus.req1_ready, 1'b0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("mr_paddr", bus.PADDR, 32'h10);
    nextCycle();
    nextCycle();
    checkOutput("mr_rsp0", bus.rsp0_valid, 1'b1);
    checkOutput("mr_rsp1_quiet", bus.rsp1_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
